// File: rtl/accum_block_looper_nch_if.sv
// Bundles the loop request, configuration and per-channel block outputs of the
// N-channel accumulation block looper. The slave modport is the looper's own view.
interface accum_block_looper_nch_if #(
  parameter int unsigned WBW   = 16,
  parameter int unsigned VDIM  = 2,
  parameter int unsigned N_CH  = 4,
  parameter int unsigned ID_BW = 3
);
  logic                            src_rdy;
  logic                            src_ack;
  logic [VDIM*WBW-1:0]             i_bofs;
  logic [VDIM*WBW-1:0]             i_agrid_step;
  logic [VDIM*WBW-1:0]             i_agrid_end;
  logic [VDIM*WBW-1:0]             i_aboundary;
  logic [N_CH-1:0]                 i_ch_en;
  logic [N_CH*(VDIM+1)*ID_BW-1:0]  i_id_begs;
  logic [N_CH*(VDIM+1)*ID_BW-1:0]  i_id_ends;
  logic [N_CH-1:0]                 abofs_rdy;
  logic [N_CH-1:0]                 abofs_ack;
  logic [N_CH*VDIM*WBW-1:0]        o_bofs;
  logic [N_CH*VDIM*WBW-1:0]        o_aofs_beg;
  logic [N_CH*VDIM*WBW-1:0]        o_aofs_end;
  logic [N_CH*ID_BW-1:0]           o_id_beg;
  logic [N_CH*ID_BW-1:0]           o_id_end;
  logic                            blkdone_dval;

  modport master (
    output src_rdy, i_bofs, i_agrid_step, i_agrid_end, i_aboundary, i_ch_en,
           i_id_begs, i_id_ends, abofs_ack,
    input  src_ack, abofs_rdy, o_bofs, o_aofs_beg, o_aofs_end, o_id_beg, o_id_end,
           blkdone_dval
  );

  modport slave (
    input  src_rdy, i_bofs, i_agrid_step, i_agrid_end, i_aboundary, i_ch_en,
           i_id_begs, i_id_ends, abofs_ack,
    output src_ack, abofs_rdy, o_bofs, o_aofs_beg, o_aofs_end, o_id_beg, o_id_end,
           blkdone_dval
  );
endinterface

// File: rtl/accum_block_looper_nch.sv
// Walks a VDIM-dimensional grid of accumulation blocks and broadcasts each block's
// offsets and id range to N_CH consumers through one-entry output slots.
module accum_block_looper_nch #(
  parameter int unsigned WBW     = 16,
  parameter int unsigned VDIM    = 2,
  parameter int unsigned N_CH    = 4,
  parameter int unsigned ID_BW   = 3,
  parameter int unsigned DONE_CH = 3
) (
  input logic                    i_clk,
  input logic                    i_rst_n,
  accum_block_looper_nch_if.slave bus
);

  localparam int unsigned LW = $clog2(VDIM + 1);

  typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

  state_e               st_q, st_d;
  logic [WBW-1:0]       aofs_q [VDIM];
  logic [WBW-1:0]       aofs_d [VDIM];
  logic [N_CH-1:0]      pending_q, pending_d;
  logic                 fin_done_q, fin_done_d;

  logic [N_CH-1:0]           rdy_q, last_q;
  logic [N_CH*VDIM*WBW-1:0]  bofs_q, abeg_q, aend_q;
  logic [N_CH*ID_BW-1:0]     idb_q, ide_q;

  logic [WBW-1:0]   step  [VDIM];
  logic [WBW-1:0]   gend  [VDIM];
  logic [WBW-1:0]   bound [VDIM];
  logic [WBW:0]     sum   [VDIM];
  logic [WBW-1:0]   aend  [VDIM];
  logic             empty_grid;

  logic [LW-1:0]    lb, le;
  logic             lb_run, le_run;
  logic [ID_BW-1:0] id_beg [N_CH];
  logic [ID_BW-1:0] id_end [N_CH];
  logic [N_CH-1:0]  skip, pend_eff, load;
  logic             is_last, busy, carry;
  logic             src_ack, blkdone;

  // Sums are one bit wider than the offsets so a carry compares as past end/boundary.
  always_comb begin
    empty_grid = 1'b0;
    for (int d = 0; d < VDIM; d++) begin
      step[d]    = bus.i_agrid_step[d*WBW +: WBW];
      gend[d]    = bus.i_agrid_end[d*WBW +: WBW];
      bound[d]   = bus.i_aboundary[d*WBW +: WBW];
      sum[d]     = {1'b0, aofs_q[d]} + {1'b0, step[d]};
      aend[d]    = (sum[d] >= {1'b0, bound[d]}) ? bound[d] : sum[d][WBW-1:0];
      empty_grid = empty_grid | (gend[d] == '0);
    end
  end

  // Begin/end levels: scan from the innermost dim outward while the condition holds.
  always_comb begin
    lb     = LW'(VDIM);
    le     = LW'(VDIM);
    lb_run = 1'b1;
    le_run = 1'b1;
    for (int i = int'(VDIM) - 1; i >= 0; i--) begin
      lb_run = lb_run & (aofs_q[i] == '0);
      le_run = le_run & (sum[i] >= {1'b0, gend[i]});
      if (lb_run) lb = LW'(i);
      if (le_run) le = LW'(i);
    end
  end

  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      id_beg[c] = bus.i_id_begs[(c * (VDIM + 1) + int'(lb)) * ID_BW +: ID_BW];
      id_end[c] = bus.i_id_ends[(c * (VDIM + 1) + int'(le)) * ID_BW +: ID_BW];
      skip[c]   = ~bus.i_ch_en[c] | (id_beg[c] == id_end[c]);
    end
    pend_eff = pending_q & ~skip;
    load     = (st_q == StRun) ? (pend_eff & ~rdy_q) : '0;
    is_last  = (le == '0);
    // A slot still full after this cycle holds the counter on the current block.
    busy     = |(rdy_q & ~bus.abofs_ack);
  end

  always_comb begin
    st_d       = st_q;
    aofs_d     = aofs_q;
    pending_d  = pending_q & ~load;
    fin_done_d = fin_done_q;
    carry      = 1'b0;
    unique case (st_q)
      StIdle: begin
        if (bus.src_rdy) begin
          if (empty_grid) begin
            st_d       = StFin;
            fin_done_d = 1'b1;
          end else begin
            st_d      = StRun;
            pending_d = bus.i_ch_en;
            for (int d = 0; d < VDIM; d++) aofs_d[d] = '0;
          end
        end
      end
      StRun: begin
        if ((pend_eff == '0) && !busy) begin
          if (is_last) begin
            st_d       = StFin;
            fin_done_d = skip[DONE_CH];
          end else begin
            carry     = 1'b1;
            pending_d = bus.i_ch_en;
            for (int d = int'(VDIM) - 1; d >= 0; d--) begin
              if (carry) begin
                if (sum[d] >= {1'b0, gend[d]}) begin
                  aofs_d[d] = '0;
                end else begin
                  aofs_d[d] = sum[d][WBW-1:0];
                  carry     = 1'b0;
                end
              end
            end
          end
        end
      end
      StFin: st_d = StIdle;
      default: st_d = StIdle;
    endcase

    src_ack = (st_q == StFin);
    blkdone = (st_q == StFin) ? fin_done_q
                              : (rdy_q[DONE_CH] & last_q[DONE_CH] & bus.abofs_ack[DONE_CH]);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_q       <= StIdle;
      pending_q  <= '0;
      fin_done_q <= 1'b0;
      for (int d = 0; d < VDIM; d++) aofs_q[d] <= '0;
    end else begin
      st_q       <= st_d;
      pending_q  <= pending_d;
      fin_done_q <= fin_done_d;
      for (int d = 0; d < VDIM; d++) aofs_q[d] <= aofs_d[d];
    end
  end

  // Output slots: a load needs an empty slot, so an ack always costs one bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rdy_q  <= '0;
      last_q <= '0;
      bofs_q <= '0;
      abeg_q <= '0;
      aend_q <= '0;
      idb_q  <= '0;
      ide_q  <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (load[c]) begin
          rdy_q[c]                          <= 1'b1;
          last_q[c]                         <= is_last;
          bofs_q[c*VDIM*WBW +: VDIM*WBW]    <= bus.i_bofs;
          for (int d = 0; d < VDIM; d++) begin
            abeg_q[(c*VDIM+d)*WBW +: WBW] <= aofs_q[d];
            aend_q[(c*VDIM+d)*WBW +: WBW] <= aend[d];
          end
          idb_q[c*ID_BW +: ID_BW]           <= id_beg[c];
          ide_q[c*ID_BW +: ID_BW]           <= id_end[c];
        end else if (bus.abofs_ack[c]) begin
          rdy_q[c] <= 1'b0;
        end
      end
    end
  end

  assign bus.src_ack      = src_ack;
  assign bus.blkdone_dval = blkdone;
  assign bus.abofs_rdy    = rdy_q;
  assign bus.o_bofs       = bofs_q;
  assign bus.o_aofs_beg   = abeg_q;
  assign bus.o_aofs_end   = aend_q;
  assign bus.o_id_beg     = idb_q;
  assign bus.o_id_end     = ide_q;

endmodule
